// File: rtl/branch_predictor_nbit_pkg.sv
// branch_predictor_nbit_pkg: shared state type, field extraction and saturating helpers.
package branch_predictor_nbit_pkg;
    typedef enum logic {INIT, RUN} state_t;

    function automatic int wnt_value(int cb);
        return (1 << (cb - 1)) - 1;
    endfunction

    function automatic logic [31:0] btb_index(logic [31:0] pc, int ib);
        return (pc >> 2) & ((32'd1 << ib) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(logic [31:0] pc, int ib, int tb);
        return (pc >> (ib + 2)) & ((32'd1 << tb) - 32'd1);
    endfunction

    function automatic logic [31:0] pht_index(logic [31:0] pc, logic [31:0] ghr, int ib, int gs);
        return btb_index(pc, ib) ^ (gs != 0 ? ghr : 32'd0);
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v, logic [31:0] max);
        return v == max ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/branch_predictor_nbit_if.sv
// branch_predictor_nbit_if: IF-stage query, EX-stage resolve and status signals.
interface branch_predictor_nbit_if;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        ready;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_taken, pred_target, pred_hit, ready, stat_branches, stat_mispred
    );
    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_taken, pred_target, pred_hit, ready, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor_nbit_sat_counter.sv
// branch_predictor_nbit_sat_counter: next value of an up/down counter clamped to 0..2**COUNTER_BITS-1.
module branch_predictor_nbit_sat_counter
    import branch_predictor_nbit_pkg::*;
#(
    parameter int COUNTER_BITS = 2
) (
    input  logic [COUNTER_BITS-1:0] i_cnt,
    input  logic                    i_up,
    output logic [COUNTER_BITS-1:0] o_next
);
    localparam logic [31:0] MAX = 32'((1 << COUNTER_BITS) - 1);

    always_comb
        o_next = i_up ? COUNTER_BITS'(sat_inc(32'(i_cnt), MAX))
                      : (i_cnt == '0 ? i_cnt : i_cnt - COUNTER_BITS'(1));
endmodule

// File: rtl/branch_predictor_nbit.sv
// branch_predictor_nbit: N-bit counter PHT plus tagged BTB with optional gshare indexing.
module branch_predictor_nbit
    import branch_predictor_nbit_pkg::*;
#(
    parameter int INDEX_BITS   = 6,
    parameter int COUNTER_BITS = 2,
    parameter int TAG_BITS     = 8,
    parameter int GSHARE       = 0,
    parameter int HIST_BITS    = 4
) (
    input logic clk,
    input logic rst,
    branch_predictor_nbit_if.slave bus
);
    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] WNT = COUNTER_BITS'(wnt_value(COUNTER_BITS));

    state_t                  r_state;
    logic [INDEX_BITS-1:0]   r_init_idx;
    logic [HIST_BITS-1:0]    r_ghr;
    logic [31:0]             r_branches;
    logic [31:0]             r_mispred;
    logic [COUNTER_BITS-1:0] r_pht [DEPTH];
    logic [DEPTH-1:0]        r_btb_valid;
    logic [TAG_BITS-1:0]     r_btb_tag [DEPTH];
    logic [31:0]             r_btb_target [DEPTH];

    logic                    w_ready;
    logic [INDEX_BITS-1:0]   w_pred_pi, w_pred_bi, w_upd_pi, w_upd_bi;
    logic [TAG_BITS-1:0]     w_pred_tag, w_upd_tag;
    logic [COUNTER_BITS-1:0] w_cnt_next;

    always_comb begin
        w_ready    = r_state == RUN;
        w_pred_bi  = INDEX_BITS'(btb_index(bus.pred_pc, INDEX_BITS));
        w_pred_pi  = INDEX_BITS'(pht_index(bus.pred_pc, 32'(r_ghr), INDEX_BITS, GSHARE));
        w_pred_tag = TAG_BITS'(pc_tag(bus.pred_pc, INDEX_BITS, TAG_BITS));
        w_upd_bi   = INDEX_BITS'(btb_index(bus.upd_pc, INDEX_BITS));
        w_upd_pi   = INDEX_BITS'(pht_index(bus.upd_pc, 32'(r_ghr), INDEX_BITS, GSHARE));
        w_upd_tag  = TAG_BITS'(pc_tag(bus.upd_pc, INDEX_BITS, TAG_BITS));
    end

    branch_predictor_nbit_sat_counter #(.COUNTER_BITS(COUNTER_BITS)) u_sat_counter (
        .i_cnt  (r_pht[w_upd_pi]),
        .i_up   (bus.upd_taken),
        .o_next (w_cnt_next)
    );

    // No write-to-read bypass: a same-cycle update becomes visible next cycle.
    assign bus.pred_hit      = w_ready & r_btb_valid[w_pred_bi] & (r_btb_tag[w_pred_bi] == w_pred_tag);
    assign bus.pred_taken    = bus.pred_hit & r_pht[w_pred_pi][COUNTER_BITS-1];
    assign bus.pred_target   = bus.pred_taken ? r_btb_target[w_pred_bi] : bus.pred_pc + 32'd4;
    assign bus.ready         = w_ready;
    assign bus.stat_branches = r_branches;
    assign bus.stat_mispred  = r_mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_idx <= '0;
            r_ghr      <= '0;
            r_branches <= '0;
            r_mispred  <= '0;
        end else if (r_state == INIT) begin
            r_pht[r_init_idx]       <= WNT;
            r_btb_valid[r_init_idx] <= 1'b0;
            r_init_idx              <= r_init_idx + INDEX_BITS'(1);
            if (&r_init_idx) r_state <= RUN;
        end else if (bus.upd_valid) begin
            r_pht[w_upd_pi] <= w_cnt_next;
            if (bus.upd_taken) begin
                r_btb_valid[w_upd_bi]  <= 1'b1;
                r_btb_tag[w_upd_bi]    <= w_upd_tag;
                r_btb_target[w_upd_bi] <= bus.upd_target;
            end
            r_ghr      <= HIST_BITS'({r_ghr, bus.upd_taken});
            r_branches <= sat_inc(r_branches, 32'hFFFF_FFFF);
            if (bus.upd_taken != bus.upd_pred_taken) r_mispred <= sat_inc(r_mispred, 32'hFFFF_FFFF);
        end
    end
endmodule

// File: tb/tb_branch_predictor_nbit.sv
// tb_branch_predictor_nbit: directed and random checks of a PC-indexed and a gshare predictor against a table model.
module tb_branch_predictor_nbit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_nbit_if bus0();
    branch_predictor_nbit_if bus1();

    branch_predictor_nbit #(.INDEX_BITS(4), .COUNTER_BITS(2), .TAG_BITS(8), .GSHARE(0), .HIST_BITS(4))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    branch_predictor_nbit #(.INDEX_BITS(4), .COUNTER_BITS(2), .TAG_BITS(8), .GSHARE(1), .HIST_BITS(2))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int tests = 0;
    int fails = 0;

    // Model: 16 entries, counters 0..3 starting at 1, tag = pc bits [13:6].
    int          m_cnt [2][16];
    bit          m_v   [2][16];
    int          m_tag [2][16];
    logic [31:0] m_tgt [2][16];
    int          m_ghr [2];
    logic [31:0] m_br  [2];
    logic [31:0] m_mp  [2];
    bit          m_ready;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bidx(logic [31:0] pc);
        return int'((pc >> 2) & 32'd15);
    endfunction

    function automatic int pidx(int k, logic [31:0] pc);
        return k == 1 ? bidx(pc) ^ (m_ghr[1] % 4) : bidx(pc);
    endfunction

    function automatic bit m_hit(int k, logic [31:0] pc);
        int b;
        b = bidx(pc);
        return m_ready && m_v[k][b] && m_tag[k][b] == int'((pc >> 6) & 32'd255);
    endfunction

    function automatic bit m_taken(int k, logic [31:0] pc);
        return m_hit(k, pc) && m_cnt[k][pidx(k, pc)] >= 2;
    endfunction

    function automatic logic [31:0] m_target(int k, logic [31:0] pc);
        return m_taken(k, pc) ? m_tgt[k][bidx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_update(int k, logic [31:0] pc, bit t, logic [31:0] tgt, bit pt);
        int p;
        if (!m_ready) return;
        p = pidx(k, pc);
        m_cnt[k][p] = t ? (m_cnt[k][p] == 3 ? 3 : m_cnt[k][p] + 1) : (m_cnt[k][p] == 0 ? 0 : m_cnt[k][p] - 1);
        if (t) begin
            m_v[k][bidx(pc)]   = 1'b1;
            m_tag[k][bidx(pc)] = int'((pc >> 6) & 32'd255);
            m_tgt[k][bidx(pc)] = tgt;
        end
        m_ghr[k] = (m_ghr[k] * 2 + int'(t)) % (k == 1 ? 4 : 16);
        if (m_br[k] != 32'hFFFF_FFFF) m_br[k]++;
        if (t != pt && m_mp[k] != 32'hFFFF_FFFF) m_mp[k]++;
    endtask

    task automatic drive(logic [31:0] qpc, logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt, logic upt);
        bus0.pred_pc = qpc; bus0.upd_valid = uv; bus0.upd_pc = upc;
        bus0.upd_taken = ut; bus0.upd_target = utgt; bus0.upd_pred_taken = upt;
        bus1.pred_pc = qpc; bus1.upd_valid = uv; bus1.upd_pc = upc;
        bus1.upd_taken = ut; bus1.upd_target = utgt; bus1.upd_pred_taken = upt;
    endtask

    task automatic chk_all(string tag);
        logic [31:0] pc;
        pc = bus0.pred_pc;
        check({tag, ".hit0"}, bus0.pred_hit, m_hit(0, pc));
        check({tag, ".tkn0"}, bus0.pred_taken, m_taken(0, pc));
        check({tag, ".tgt0"}, bus0.pred_target, m_target(0, pc));
        check({tag, ".hit1"}, bus1.pred_hit, m_hit(1, pc));
        check({tag, ".tkn1"}, bus1.pred_taken, m_taken(1, pc));
        check({tag, ".tgt1"}, bus1.pred_target, m_target(1, pc));
        check({tag, ".rdy0"}, bus0.ready, m_ready);
        check({tag, ".rdy1"}, bus1.ready, m_ready);
        check({tag, ".br0"}, bus0.stat_branches, m_br[0]);
        check({tag, ".mp0"}, bus0.stat_mispred, m_mp[0]);
        check({tag, ".br1"}, bus1.stat_branches, m_br[1]);
        check({tag, ".mp1"}, bus1.stat_mispred, m_mp[1]);
    endtask

    task automatic step(string tag, logic [31:0] qpc, logic uv, logic [31:0] upc, logic ut,
                        logic [31:0] utgt, logic upt);
        drive(qpc, uv, upc, ut, utgt, upt);
        #1;
        chk_all({tag, ".pre"});
        @(posedge clk); #1;
        if (uv) begin
            m_update(0, upc, ut, utgt, upt);
            m_update(1, upc, ut, utgt, upt);
        end
        bus0.upd_valid = 1'b0;
        bus1.upd_valid = 1'b0;
        #1;
        chk_all({tag, ".post"});
    endtask

    task automatic do_reset(logic busy_upd);
        rst = 1'b1;
        drive(32'hFFFF_FFFC, busy_upd, 32'h40, 1'b1, 32'h100, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_cnt[k][i] = 1; m_v[k][i] = 1'b0; m_tag[k][i] = 0; m_tgt[k][i] = '0;
            end
            m_ghr[k] = 0; m_br[k] = '0; m_mp[k] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            drive(i == 0 ? 32'hFFFF_FFFC : 32'($urandom_range(0, 127)) << 2, busy_upd, 32'h40, 1'b1, 32'h100, 1'b0);
            #1;
            chk_all("init");
            if (i == 0) check("init_wrap", bus0.pred_target, 32'h0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_all("ready");
        check("ready_hi", bus0.ready, 1'b1);
    endtask

    initial begin
        logic [31:0] pc, tgt;
        logic        t;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_reset(1'b1);

        step("hyst1", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        step("hyst2", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        check("hyst_t2", bus0.pred_taken, 1'b1);
        check("hyst_tgt", bus0.pred_target, 32'h100);
        step("hyst3", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        check("hyst_n1", bus0.pred_taken, 1'b1);
        step("hyst4", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        check("hyst_n2", bus0.pred_taken, 1'b0);
        check("hyst_ft", bus0.pred_target, 32'h44);

        for (int i = 0; i < 5; i++) step("sat_t", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 2; i++) step("sat_n", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        check("sat_3_1", bus0.pred_taken, 1'b0);
        for (int i = 0; i < 10; i++) step("sat_floor", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        step("sat_up1", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        check("no_underflow", bus0.pred_taken, 1'b0);
        step("sat_up2", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        check("sat_up2_t", bus0.pred_taken, 1'b1);

        step("alias_q", 32'h440, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("alias_hit", bus0.pred_hit, 1'b0);
        check("alias_tkn", bus0.pred_taken, 1'b0);
        step("alias_u", 32'h40, 1'b1, 32'h440, 1'b1, 32'h200, 1'b0);
        check("alias_evict", bus0.pred_hit, 1'b0);

        step("collide", 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
        check("collide_new", bus0.pred_hit, 1'b1);
        check("collide_tgt", bus0.pred_target, 32'h300);

        step("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("wrap_tgt", bus0.pred_target, 32'h0);

        do_reset(1'b0);
        for (int j = 0; j < 8; j++) step("gshare", 32'h80, 1'b1, 32'h80, j % 2 == 0, 32'h180, m_taken(1, 32'h80));
        check("gs_pred", bus1.pred_taken, 1'b1);
        check("gs_tgt", bus1.pred_target, 32'h180);
        check("pc_only_pred", bus0.pred_taken, 1'b0);
        check("gs_br", bus1.stat_branches, 32'd8);
        check("gs_mp", bus1.stat_mispred, 32'd2);

        do_reset(1'b1);
        step("clr80", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("clr_hit1", bus1.pred_hit, 1'b0);
        step("clr40", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("clr_hit0", bus0.pred_hit, 1'b0);

        for (int i = 0; i < 400; i++) begin
            pc  = 32'($urandom_range(0, 127)) << 2;
            tgt = $urandom & 32'hFFFF_FFFC;
            t   = 1'($urandom_range(0, 1));
            step("rand", 32'($urandom_range(0, 127)) << 2, $urandom_range(0, 3) != 0, pc, t, tgt,
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_predictor_nbit.md
Name: branch_predictor_nbit

Overview:
- Parametrised successor to the pipeline's single-bit branch predictor.
- Direct-mapped pattern history table (PHT) of N-bit saturating counters plus a tagged branch target buffer (BTB); optional gshare indexing via a global history register (GHR).
- IF stage queries it combinationally with the fetch PC; EX stage writes back resolved branch outcomes.
- Includes a table-initialisation sweep FSM and saturating accuracy counters.

Parameters:
- INDEX_BITS, 6, log2 of table depth; DEPTH = 2**INDEX_BITS entries (PHT and BTB).
- COUNTER_BITS, 2, saturating counter width, 1..4; COUNTER_BITS=1 reproduces 1-bit prediction.
- TAG_BITS, 8, BTB tag width taken from the PC above the index bits.
- GSHARE, 0, 0 = PHT indexed by PC only; 1 = PC index XOR GHR.
- HIST_BITS, 4, GHR width, 1..INDEX_BITS; GHR is zero-extended to INDEX_BITS before the XOR.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- pred_pc  in  32  fetch PC (IF)
- pred_taken  out  1  predicted direction
- pred_target  out  32  next-PC prediction
- pred_hit  out  1  BTB tag hit for pred_pc
- upd_valid  in  1  resolved branch present in EX this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual taken target
- upd_pred_taken  in  1  direction that was predicted for this branch (carried down the pipe)
- ready  out  1  initialisation complete
- stat_branches  out  32  resolved-branch count
- stat_mispred  out  32  direction-mispredict count

Behaviour:
- Field extraction:
  - idx_pc = pc[INDEX_BITS+1:2].
  - tag = pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2].
  - PHT index = idx_pc XOR (GSHARE ? {0,GHR} : 0).
  - BTB index = idx_pc always.
- FSM, 2 states, INIT and RUN:
  - rst=1 at any edge: state <= INIT, init_idx <= 0, GHR <= 0, both stat counters <= 0. Reset mid-sweep or mid-RUN restarts the sweep.
  - INIT: each cycle writes PHT[init_idx] <= WNT and BTB_valid[init_idx] <= 0, then init_idx++.
  - WNT (weakly not-taken) = 2**(COUNTER_BITS-1)-1; for COUNTER_BITS=1 this is 0.
  - After writing entry DEPTH-1: state <= RUN. ready=1 exactly DEPTH cycles after rst deasserts.
  - INIT: upd_valid is ignored (no table, GHR or stat change).
- Prediction (combinational, zero latency):
  - pred_hit = ready & BTB_valid[bi] & (BTB_tag[bi] == tag).
  - pred_taken = pred_hit & PHT[pi][COUNTER_BITS-1].
  - pred_target = pred_taken ? BTB_target[bi] : pred_pc+4, with 32-bit wrap: 0xFFFFFFFC+4 = 0.
  - ready=0 forces pred_taken=0 and pred_target=pred_pc+4.
- Update (RUN & upd_valid), all at the same edge:
  - PHT counter: increments if upd_taken, else decrements; saturates at 0 and 2**COUNTER_BITS-1.
  - PHT index uses the GHR value before this edge's shift.
  - If upd_taken: BTB[bi] <= {valid=1, tag, upd_target}, replacing any alias. Not-taken never allocates or invalidates a BTB entry.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}; for HIST_BITS=1, GHR <= upd_taken. Shift is non-speculative, at resolve.
  - stat_branches++, saturating at 0xFFFFFFFF.
  - If upd_taken != upd_pred_taken: stat_mispred++, also saturating. Target mismatch alone is not counted.
- Simultaneous predict and update to the same entry: prediction returns the pre-edge value (no bypass); the new value is visible the following cycle.
- Reset values of outputs:
  - ready=0, stat_*=0.
  - pred_taken=0, pred_hit=0, pred_target=pred_pc+4 for the whole INIT period.

Decomposition:
- Shared package bp_pkg:
  - state enum {INIT, RUN};
  - wnt_value(COUNTER_BITS) constant function;
  - pht_index/btb_index/tag field-extraction functions;
  - saturating-increment helper reused for counters and stats.
- One natural sub-module: sat_counter (COUNTER_BITS-wide up/down saturating next-value logic), instantiated once on the write path. Tables stay flop arrays in the top.

Test Plan:
- Init: INDEX_BITS=4, pulse rst 1 cycle -> ready low exactly 16 cycles then high; pred_taken=0, pred_target=pred_pc+4, stat_*=0 throughout.
- 2-bit hysteresis: update PC 0x40 taken to 0x100 twice -> pred_taken=1, pred_target=0x100. One not-taken -> still 1. Second not-taken -> 0, pred_target=0x44.
- Saturation: 5 taken updates then 2 not-taken at 0x40 -> counter 3,3,3,2,1, predicts not-taken. 10 not-taken -> counter stays 0, no underflow.
- Aliasing: train 0x40 taken, then query 0x440 (same index, different tag) -> pred_hit=0, pred_taken=0. Update 0x440 taken to 0x200 -> 0x40 now misses.
- Gshare: GSHARE=1, HIST_BITS=2, alternating T/N at the same PC for 8 updates -> PHT entries for GHR 01/10 diverge and the alternating pattern predicts correctly after warm-up. stat_mispred counts only mismatches of upd_pred_taken.
- Reset mid-RUN and collision: rst asserted with trained entries -> all tables cleared after the 16-cycle sweep. Same-cycle update+query of 0x40 -> old prediction that cycle, new one the next cycle.
